// File: rtl/pipe_mux_nx1.sv
// Registered NUM_IN:1 channel mux with valid/ready handshake; out-of-range selects yield zero with sel_err.
// Define PIPE_MUX_SKID_EN to add a one-entry skid register so in_ready no longer depends on out_ready.
module pipe_mux_nx1 #(
   parameter int WIDTH  = 64,
   parameter int NUM_IN = 3,
   localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
);

   logic [WIDTH-1:0] chan [NUM_IN];
   logic [WIDTH-1:0] pick_data;
   logic             pick_err;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
         assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Any select value with no matching channel falls through to zero data and the error flag.
   always_comb begin
      pick_data = '0;
      pick_err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            pick_data = chan[k];
            pick_err  = 1'b0;
         end
      end
   end

`ifdef PIPE_MUX_SKID_EN
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
`else
   typedef enum logic {ST_EMPTY, ST_ONE} state_t;
`endif

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic             err_reg, err_next;
   logic             accept, drain;

`ifdef PIPE_MUX_SKID_EN
   logic [WIDTH-1:0] skid_data_reg, skid_data_next;
   logic             skid_err_reg, skid_err_next;

   // Only registered state feeds in_ready, breaking the out_ready -> in_ready path.
   assign in_ready = !reset && (state_reg != ST_TWO);
`else
   assign in_ready = !reset && (!out_valid || out_ready);
`endif

   assign out_valid = (state_reg != ST_EMPTY);
   assign out_data  = data_reg;
   assign sel_err   = err_reg;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      err_next   = err_reg;
`ifdef PIPE_MUX_SKID_EN
      skid_data_next = skid_data_reg;
      skid_err_next  = skid_err_reg;
`endif
      case (state_reg)
         ST_EMPTY: begin
            if (accept) begin
               state_next = ST_ONE;
               data_next  = pick_data;
               err_next   = pick_err;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               data_next = pick_data;
               err_next  = pick_err;
            end
`ifdef PIPE_MUX_SKID_EN
            else if (accept) begin
               state_next     = ST_TWO;
               skid_data_next = pick_data;
               skid_err_next  = pick_err;
            end
`endif
            else if (drain) begin
               state_next = ST_EMPTY;
            end
         end
`ifdef PIPE_MUX_SKID_EN
         ST_TWO: begin
            if (drain) begin
               state_next = ST_ONE;
               data_next  = skid_data_reg;
               err_next   = skid_err_reg;
            end
         end
`endif
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_EMPTY;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
      end
   end

`ifdef PIPE_MUX_SKID_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         skid_data_reg <= '0;
         skid_err_reg  <= 1'b0;
      end else begin
         skid_data_reg <= skid_data_next;
         skid_err_reg  <= skid_err_next;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Self-checking bench for pipe_mux_nx1: directed scenarios plus random traffic against a queue model.
module tb_pipe_mux_nx1;
   localparam int WIDTH   = 64;
   localparam int NUM_IN  = 3;
   localparam int SEL_W   = 2;
   localparam int NUM_IN5 = 5;
   localparam int SEL_W5  = 3;
`ifdef PIPE_MUX_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_IN*WIDTH-1:0]  in_data;
   logic [SEL_W-1:0]         sel;
   logic                     in_valid, in_ready, out_valid, out_ready, sel_err;
   logic [WIDTH-1:0]         out_data;

   logic [NUM_IN5*WIDTH-1:0] in_data5;
   logic [SEL_W5-1:0]        sel5;
   logic                     in_valid5, in_ready5, out_valid5, out_ready5, sel_err5;
   logic [WIDTH-1:0]         out_data5;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             e;
   } word_t;

   word_t q[$];
   int    nchecks = 0;
   int    nfail   = 0;
   bit    last_acc;

   always #5 clk = ~clk;

   pipe_mux_nx1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .sel_err(sel_err)
   );

   pipe_mux_nx1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN5)) dut5 (
      .clk(clk), .reset(reset), .in_data(in_data5), .sel(sel5), .in_valid(in_valid5),
      .in_ready(in_ready5), .out_data(out_data5), .out_valid(out_valid5),
      .out_ready(out_ready5), .sel_err(sel_err5)
   );

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference selection: channel s when it exists, otherwise zero with the error flag.
   function automatic word_t ref_word(input logic [NUM_IN*WIDTH-1:0] data, input int s);
      word_t w;
      if (s < NUM_IN) begin
         w.d = data[s*WIDTH +: WIDTH];
         w.e = 1'b0;
      end else begin
         w.d = '0;
         w.e = 1'b1;
      end
      return w;
   endfunction

   // Readiness from occupancy: skid build holds up to two words, plain build one (or passes through).
   function automatic bit exp_ready();
      if (reset) return 1'b0;
      if (SKID) return q.size() < 2;
      return (q.size() == 0) || out_ready;
   endfunction

   task automatic tick();
      bit    acc, drn;
      word_t w;
      acc = in_valid && exp_ready();
      drn = (q.size() != 0) && out_ready;
      w   = ref_word(in_data, int'(sel));
      @(posedge clk);
      last_acc = acc;
      if (reset) begin
         q.delete();
      end else begin
         if (drn) begin
            $display("out  data=%h sel_err=%b", q[0].d, q[0].e);
            void'(q.pop_front());
         end
         if (acc) begin
            $display("in   sel=%0d data=%h sel_err=%b", sel, w.d, w.e);
            q.push_back(w);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = '0; in_data = '0;
      in_valid5 = 1'b0; out_ready5 = 1'b1; sel5 = '0; in_data5 = '0;
      repeat (2) begin
         @(negedge clk); #1;
         nchecks++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
         tick();
      end
      @(negedge clk); reset = 1'b0; #1;
      nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      nchecks++; if (out_data !== '0) begin nfail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      nchecks++; if (sel_err !== 1'b0) begin nfail++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
      nchecks++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
      nchecks++; if (out_valid5 !== 1'b0) begin nfail++; $display("FAIL reset_out_valid5 got=%b exp=0", out_valid5); end
      tick();
   endtask

   task automatic test_select();
      @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; sel = 2'd2;
      in_data = {64'hC, rnd64(), rnd64()}; #1; tick();
      @(negedge clk); in_valid = 1'b0; #1;
      nchecks++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL sel2_valid got=%b exp=1", out_valid); end
      nchecks++; if (out_data !== 64'hC) begin nfail++; $display("FAIL sel2_data got=%h exp=c", out_data); end
      nchecks++; if (sel_err !== 1'b0) begin nfail++; $display("FAIL sel2_err got=%b exp=0", sel_err); end
      tick();
      @(negedge clk); #1;
      nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL sel2_empty got=%b exp=0", out_valid); end
      tick();
      @(negedge clk); in_valid = 1'b1; sel = 2'd3; in_data = {rnd64(), rnd64(), rnd64()}; #1; tick();
      @(negedge clk); sel = 2'd0; in_data = {rnd64(), rnd64(), 64'hA}; #1;
      nchecks++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL sel3_valid got=%b exp=1", out_valid); end
      nchecks++; if (out_data !== '0) begin nfail++; $display("FAIL sel3_data got=%h exp=0", out_data); end
      nchecks++; if (sel_err !== 1'b1) begin nfail++; $display("FAIL sel3_err got=%b exp=1", sel_err); end
      tick();
      @(negedge clk); in_valid = 1'b0; #1;
      nchecks++; if (out_data !== 64'hA) begin nfail++; $display("FAIL sel0_data got=%h exp=a", out_data); end
      nchecks++; if (sel_err !== 1'b0) begin nfail++; $display("FAIL sel0_err got=%b exp=0", sel_err); end
      tick();
   endtask

   task automatic test_skid_fill();
      bit pending;
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      in_data = {rnd64(), rnd64(), 64'h1}; #1;
      nchecks++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL fill_first_ready got=%b exp=1", in_ready); end
      tick();
      @(negedge clk); in_data = {rnd64(), rnd64(), 64'h2}; #1;
      nchecks++; if (in_ready !== SKID) begin nfail++; $display("FAIL fill_second_ready got=%b exp=%b", in_ready, SKID); end
      tick();
      pending = !last_acc;
      @(negedge clk); in_valid = pending; #1;
      nchecks++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
      nchecks++; if (out_data !== 64'h1) begin nfail++; $display("FAIL fill_hold_data got=%h exp=1", out_data); end
      tick();
      @(negedge clk); out_ready = 1'b1; #1;
      nchecks++; if (out_valid !== 1'b1 || out_data !== 64'h1) begin
         nfail++; $display("FAIL fill_drain1 got=%b/%h exp=1/1", out_valid, out_data);
      end
      tick();
      pending = pending && !last_acc;
      @(negedge clk); in_valid = pending; #1;
      nchecks++; if (out_valid !== 1'b1 || out_data !== 64'h2) begin
         nfail++; $display("FAIL fill_drain2 got=%b/%h exp=1/2", out_valid, out_data);
      end
      tick();
      @(negedge clk); in_valid = 1'b0; #1;
      nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL fill_empty got=%b exp=0", out_valid); end
      tick();
   endtask

   task automatic test_random_traffic();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         sel       = SEL_W'($urandom_range(0, 3));
         in_data   = {rnd64(), rnd64(), rnd64()};
         #1;
         nchecks++; if (in_ready !== exp_ready()) begin nfail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready()); end
         nchecks++; if (out_valid !== (q.size() != 0)) begin nfail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
         if (q.size() != 0) begin
            nchecks++; if (out_data !== q[0].d) begin nfail++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", c, out_data, q[0].d); end
            nchecks++; if (sel_err !== q[0].e) begin nfail++; $display("FAIL rand_sel_err cyc=%0d got=%b exp=%b", c, sel_err, q[0].e); end
         end
         tick();
      end
      repeat (4) begin
         @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1; tick();
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         in_valid = (c < 10); out_ready = 1'b1; sel = 2'd0;
         in_data = {rnd64(), rnd64(), 64'(c)};
         #1;
         if (c < 10) begin
            nchecks++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", c, in_ready); end
         end
         if (c >= 1 && c <= 10) begin
            nchecks++; if (out_valid !== 1'b1 || out_data !== 64'(c - 1) || sel_err !== 1'b0) begin
               nfail++; $display("FAIL b2b_out cyc=%0d got=%b/%h exp=1/%h", c, out_valid, out_data, 64'(c - 1));
            end
         end else begin
            nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL b2b_idle cyc=%0d got=%b exp=0", c, out_valid); end
         end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
      in_data = {rnd64(), 64'h11, rnd64()}; #1; tick();
      @(negedge clk); in_data = {rnd64(), 64'h22, rnd64()}; #1; tick();
      @(negedge clk); in_valid = 1'b0; reset = 1'b1; #1;
      nchecks++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      tick();
      @(negedge clk); reset = 1'b0; out_ready = 1'b1; #1;
      nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      nchecks++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL midrst_release_ready got=%b exp=1", in_ready); end
      nchecks++; if (out_data !== '0) begin nfail++; $display("FAIL midrst_out_data got=%h exp=0", out_data); end
      tick();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         nchecks++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", c, out_valid); end
         tick();
      end
   endtask

   task automatic test_wide_sel();
      logic [WIDTH-1:0] exp_d;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         in_valid5 = 1'b1; out_ready5 = 1'b1; sel5 = SEL_W5'(s);
         for (int k = 0; k < NUM_IN5; k++) in_data5[k*WIDTH +: WIDTH] = rnd64();
         if (s < NUM_IN5) exp_d = in_data5[s*WIDTH +: WIDTH];
         else exp_d = '0;
         #1;
         nchecks++; if (in_ready5 !== 1'b1) begin nfail++; $display("FAIL wide_ready sel=%0d got=%b exp=1", s, in_ready5); end
         tick();
         @(negedge clk); in_valid5 = 1'b0; #1;
         $display("out5 sel=%0d data=%h sel_err=%b", s, out_data5, sel_err5);
         nchecks++; if (out_valid5 !== 1'b1 || out_data5 !== exp_d) begin
            nfail++; $display("FAIL wide_data sel=%0d got=%b/%h exp=1/%h", s, out_valid5, out_data5, exp_d);
         end
         nchecks++; if (sel_err5 !== (s >= NUM_IN5)) begin
            nfail++; $display("FAIL wide_err sel=%0d got=%b exp=%b", s, sel_err5, s >= NUM_IN5);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_select();
      test_skid_fill();
      test_random_traffic();
      test_back_to_back();
      test_reset_midstream();
      test_wide_sel();
      $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
      $finish;
   end

endmodule

// File: doc/pipe_mux_nx1.md
PIPE_MUX_NX1 -- requirements
Module: pipe_mux_nx1

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, 64, bit width of each data channel; SHALL be >= 1.
REQ-003 Parameter NUM_IN, 3, number of input channels; SHALL be >= 2.
REQ-004 Derived SEL_W SHALL equal ceil(log2(NUM_IN)), min 1.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_data  input  NUM_IN*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  channel select, sampled with in_data.
REQ-009 in_valid  input  1  producer has a word.
REQ-010 in_ready  output  1  block can accept a word this cycle.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_valid  output  1  out_data and sel_err are valid.
REQ-013 out_ready  input  1  consumer accepts out_data.
REQ-014 sel_err  output  1  word was produced from an out-of-range sel.

Function
REQ-015 Input transfer SHALL occur at a rising clk edge when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 For sel < NUM_IN, the captured word SHALL be channel sel, with sel_err=0.
REQ-017 For sel >= NUM_IN, the captured word SHALL be all zeros with sel_err=1; no stale-value hold.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N is on out_data with out_valid=1 after edge N.
REQ-019 While out_valid=1 and out_ready=0, out_data and sel_err SHALL remain stable.
REQ-020 Words SHALL leave in acceptance order; none dropped or duplicated.
REQ-021 Control SHALL be a state machine: EMPTY (no word held), ONE (output register full), TWO (output plus skid full; SKID build only).
REQ-022 Transitions: EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE stays ONE on simultaneous accept and drain; ONE->TWO on accept without drain; TWO->ONE on drain, skid word moving to output the same edge.
REQ-023 in_valid, sel, and in_data SHALL be ignored when in_ready=0.
REQ-024 With out_valid=1 and out_ready=1 every cycle and in_valid=1, the block SHALL sustain one word per cycle with no bubbles.

Reset
REQ-025 At a rising edge with reset=1: state=EMPTY, out_valid=0, out_data=0, sel_err=0, skid cleared.
REQ-026 in_ready SHALL be 0 while reset=1; reset mid-operation (including in state TWO) SHALL discard all held words.
REQ-027 In the first cycle after reset deasserts, in_ready SHALL be 1.

Configuration
REQ-028 Macro PIPE_MUX_SKID_EN SHALL select the buffering mode.
REQ-029 With PIPE_MUX_SKID_EN defined: a one-entry skid register is included, state TWO exists, and in_ready = !reset && state!=TWO, driven from a register with no combinational path from out_ready.
REQ-030 Without it: state TWO is absent, and in_ready = !reset && (!out_valid || out_ready), combinational from out_ready.

Verification (WIDTH=64, NUM_IN=3 unless stated)
REQ-031 Reset, then in_data ch2=0xC, sel=2, in_valid for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0xC, sel_err=0, then out_valid=0.
REQ-032 sel=3, in_valid=1 -> out_data=0x0, sel_err=1; following word with sel=0, ch0=0xA -> out_data=0xA, sel_err=0.
REQ-033 out_ready=0, offer words 0x1 then 0x2 -> SKID: both accepted, in_ready=0 after the second, out_data holds 0x1; out_ready=1 gives 0x1 then 0x2 on consecutive cycles. Non-SKID: 0x2 waits until 0x1 drains.
REQ-034 Stream 10 words 0x0..0x9 with in_valid=out_ready=1 -> 10 consecutive outputs in order, no bubble.
REQ-035 Fill to TWO, assert reset 1 cycle -> out_valid=0, in_ready=0 during reset, in_ready=1 the next cycle, no stale word emitted.
REQ-036 NUM_IN=5 (SEL_W=3): sel=4 -> channel 4; sel=5,6,7 -> out_data=0, sel_err=1.
